// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one MUL among NUM_REQ requesters, with in-order result routing.
// Optional stall statistics counter enabled by defining MUL_ARB_STATS_EN.
module mul_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int LOG_NUM_REQ   = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int REP_INFO      = 16,
  parameter int LOG_MAX_OPS   = 16,
  parameter int TAG_SLOTS     = 8,
  parameter int LOG_TAG_SLOTS = 3,
  localparam int W            = 2*DATA_WIDTH + REP_INFO
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   configure,
  input  logic [LOG_MAX_OPS-1:0] num_ops,
  input  logic [NUM_REQ-1:0]     enable_mask,
  output logic                   busy,
  output logic                   done,
  input  logic [NUM_REQ*W-1:0]   req_data_in,
  input  logic [NUM_REQ-1:0]     req_valid_in,
  output logic [NUM_REQ-1:0]     req_avail_out,
  output logic [W-1:0]           mul_data_out,
  output logic                   mul_valid_out,
  input  logic                   mul_avail_in,
  input  logic [W-1:0]           mul_data_in,
  input  logic                   mul_valid_in,
  output logic                   mul_avail_out,
  output logic [W-1:0]           rsp_data_out,
  output logic [NUM_REQ-1:0]     rsp_valid_out,
  input  logic [NUM_REQ-1:0]     rsp_avail_in,
  output logic [31:0]            stall_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic                   done_nxt;
  logic                   cfg_accept;
  logic                   grant;
  logic                   gnt_found;
  logic [LOG_NUM_REQ-1:0] gnt_id;
  logic [LOG_NUM_REQ-1:0] rr_ptr;
  logic [NUM_REQ-1:0]     mask_q;
  logic [NUM_REQ-1:0]     eligible;
  logic [LOG_MAX_OPS-1:0] issue_cnt;
  logic [LOG_MAX_OPS-1:0] resp_cnt;

  logic [NUM_REQ-1:0]     buf_nonempty;
  logic [W-1:0]           buf_head [NUM_REQ];

  // ---------------- per-requester 2-slot buffers ----------------
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_buf
    logic [W-1:0] mem [2];
    logic         wr_ptr, rd_ptr;
    logic [1:0]   cnt;
    logic         push, pop;

    assign req_avail_out[g] = (cnt != 2'd2);
    assign push             = req_valid_in[g] & req_avail_out[g];
    assign pop              = grant && (gnt_id == LOG_NUM_REQ'(g));
    assign buf_nonempty[g]  = (cnt != 2'd0);
    assign buf_head[g]      = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= req_data_in[g*W +: W];
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // ---------------- tag FIFO ----------------
  logic [LOG_NUM_REQ-1:0]   tag_mem [TAG_SLOTS];
  logic [LOG_TAG_SLOTS-1:0] tag_wr, tag_rd;
  logic [LOG_TAG_SLOTS:0]   tag_cnt;
  logic                     tag_empty, tag_full, tag_pop;
  logic [LOG_NUM_REQ-1:0]   head;

  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == (LOG_TAG_SLOTS+1)'(TAG_SLOTS));
  assign tag_pop   = mul_valid_in & ~tag_empty;
  assign head      = tag_mem[tag_rd];

  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr] <= gnt_id;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      tag_cnt <= '0;
    end else begin
      if (grant)   tag_wr <= tag_wr + 1'b1;
      if (tag_pop) tag_rd <= tag_rd + 1'b1;
      tag_cnt <= tag_cnt + {{LOG_TAG_SLOTS{1'b0}}, grant} - {{LOG_TAG_SLOTS{1'b0}}, tag_pop};
    end
  end

  // ---------------- return path ----------------
  assign mul_avail_out = ~tag_empty & rsp_avail_in[head];
  assign rsp_data_out  = mul_data_in;
  assign rsp_valid_out = mul_valid_in ? (NUM_REQ'(1) << head) : '0;

  // ---------------- round-robin grant ----------------
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = rr_ptr;
    eligible  = mask_q & buf_nonempty;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= 32'(NUM_REQ)) idx = idx - 32'(NUM_REQ);
      if (!gnt_found && eligible[idx[LOG_NUM_REQ-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[LOG_NUM_REQ-1:0];
      end
    end
  end

  assign grant = (state == RUN) && (issue_cnt != '0) && mul_avail_in && !tag_full && gnt_found;

  // ---------------- control FSM ----------------
  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    cfg_accept = 1'b0;
    case (state)
      IDLE: begin
        if (configure) begin
          cfg_accept = 1'b1;
          if (num_ops == '0) done_nxt  = 1'b1;
          else               state_nxt = RUN;
        end
      end
      RUN: begin
        if (grant && issue_cnt == LOG_MAX_OPS'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // finish on the cycle the last response is taken, so done is not delayed
        if (resp_cnt == '0 || (resp_cnt == LOG_MAX_OPS'(1) && mul_valid_in)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      done          <= 1'b0;
      rr_ptr        <= '0;
      mask_q        <= '0;
      issue_cnt     <= '0;
      resp_cnt      <= '0;
      mul_valid_out <= 1'b0;
      mul_data_out  <= '0;
    end else begin
      state         <= state_nxt;
      done          <= done_nxt;
      mul_valid_out <= grant;
      if (grant) begin
        mul_data_out <= buf_head[gnt_id];
        rr_ptr       <= (gnt_id == LOG_NUM_REQ'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
      if (cfg_accept) begin
        issue_cnt <= num_ops;
        resp_cnt  <= num_ops;
        mask_q    <= enable_mask;
      end else begin
        if (grant) issue_cnt <= issue_cnt - 1'b1;
        if (mul_valid_in && resp_cnt != '0) resp_cnt <= resp_cnt - 1'b1;
      end
    end
  end

  // ---------------- optional statistics ----------------
`ifdef MUL_ARB_STATS_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (!rst)
      stall_q <= '0;
    else if (cfg_accept)
      stall_q <= '0;
    else if (state == RUN && issue_cnt != '0 && (|eligible) && !grant && stall_q != '1)
      stall_q <= stall_q + 1'b1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural 4-deep MUL and issue/result scoreboards.
module tb_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int W       = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 configure;
  logic [15:0]          num_ops;
  logic [NUM_REQ-1:0]   enable_mask;
  logic                 busy, done;
  logic [NUM_REQ*W-1:0] req_data_in;
  logic [NUM_REQ-1:0]   req_valid_in, req_avail_out;
  logic [W-1:0]         mul_data_out, mul_data_in, rsp_data_out;
  logic                 mul_valid_out, mul_avail_in, mul_valid_in, mul_avail_out;
  logic [NUM_REQ-1:0]   rsp_valid_out, rsp_avail_in;
  logic [31:0]          stall_cycles;

  int unsigned n_chk = 0, n_fail = 0, done_cnt = 0, exp_stall = 0;
  logic [W-1:0]  iss_q [$];
  logic [35:0]   rsp_q [$];
  logic          mul_block;

  always #5 clk = ~clk;

  mul_arbiter #(.NUM_REQ(4), .LOG_NUM_REQ(2), .DATA_WIDTH(8), .REP_INFO(16),
                .LOG_MAX_OPS(16), .TAG_SLOTS(8), .LOG_TAG_SLOTS(3)) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_ops(num_ops),
    .enable_mask(enable_mask), .busy(busy), .done(done),
    .req_data_in(req_data_in), .req_valid_in(req_valid_in), .req_avail_out(req_avail_out),
    .mul_data_out(mul_data_out), .mul_valid_out(mul_valid_out), .mul_avail_in(mul_avail_in),
    .mul_data_in(mul_data_in), .mul_valid_in(mul_valid_in), .mul_avail_out(mul_avail_out),
    .rsp_data_out(rsp_data_out), .rsp_valid_out(rsp_valid_out), .rsp_avail_in(rsp_avail_in),
    .stall_cycles(stall_cycles)
  );

  // MUL model: result = {rep_info, weight*activation}; avail drops at 3 entries (almost full)
  logic [W-1:0] mq [4];
  logic [1:0]   mq_rd, mq_wr;
  logic [2:0]   mq_cnt;
  logic         m_pop;

  function automatic logic [W-1:0] mres(logic [W-1:0] w);
    logic [15:0] p;
    p = w[15:8] * w[7:0];
    return {w[31:16], p};
  endfunction

  function automatic logic [W-1:0] word(int r, int k);
    logic [7:0] a, b;
    a = 8'(37*r + 11*k + 5);
    b = 8'(r + 2*k + 2);
    return {8'hC0, 8'(r*16 + k), b, a};
  endfunction

  assign m_pop        = (mq_cnt != 3'd0) && mul_avail_out;
  assign mul_valid_in = m_pop;
  assign mul_data_in  = mq[mq_rd];
  assign mul_avail_in = (mq_cnt < 3'd3) && !mul_block;

  always @(posedge clk) begin
    if (!rst) begin
      mq_rd <= '0; mq_wr <= '0; mq_cnt <= '0;
    end else begin
      if (mul_valid_out) begin
        mq[mq_wr] <= mres(mul_data_out);
        mq_wr     <= mq_wr + 2'd1;
      end
      if (m_pop) mq_rd <= mq_rd + 2'd1;
      mq_cnt <= mq_cnt + 3'(mul_valid_out) - 3'(m_pop);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (mul_valid_out === 1'b1) begin
        check("mul_overflow", (mq_cnt == 3'd4) && !m_pop, 0);
        check("issue_pending", iss_q.size() != 0, 1);
        if (iss_q.size() != 0) check("issue_word", mul_data_out, iss_q.pop_front());
      end
      if (rsp_valid_out !== '0) begin
        check("rsp_pending", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) check("rsp", {rsp_valid_out, rsp_data_out}, rsp_q.pop_front());
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("done_busy", busy, 0);
      end
      if (busy === 1'b1 && mul_block) exp_stall++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input int r, input logic [W-1:0] w);
    int unsigned n = 0;
    while (req_avail_out[r] !== 1'b1 && n < 200) begin tick(); n++; end
    check("push_avail", req_avail_out[r], 1);
    req_data_in[r*W +: W] = w;
    req_valid_in[r] = 1'b1;
    tick();
    req_valid_in[r] = 1'b0;
  endtask

  task automatic exp_op(input int r, input logic [W-1:0] w);
    iss_q.push_back(w);
    rsp_q.push_back({4'(1 << r), mres(w)});
  endtask

  task automatic cfg(input int n, input logic [3:0] m);
    configure = 1'b1; num_ops = 16'(n); enable_mask = m;
    tick();
    configure = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while ((busy !== 1'b0 || rsp_q.size() != 0) && n < 400) begin tick(); n++; end
    check({tag, "_timeout"}, n < 400, 1);
    tick(); tick();
    check({tag, "_issue_left"}, iss_q.size(), 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    done_cnt = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mul_valid"}, mul_valid_out, 0);
    check({tag, "_mul_data"}, mul_data_out, 0);
    check({tag, "_rsp_valid"}, rsp_valid_out, 0);
    check({tag, "_mul_avail"}, mul_avail_out, 0);
    check({tag, "_req_avail"}, req_avail_out, 4'hF);
    check({tag, "_stall"}, stall_cycles, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; tick();
    iss_q.delete(); rsp_q.delete(); done_cnt = 0;
    rst = 1'b1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; configure = 1'b0; num_ops = '0; enable_mask = '0;
    req_data_in = '0; req_valid_in = '0; rsp_avail_in = '1; mul_block = 1'b0;
    tick(); tick();
    check_reset("reset");
    rst = 1'b1; tick();

    // all four full, round-robin from pointer 0, back-to-back grants
    for (int r = 0; r < 4; r++) for (int k = 0; k < 2; k++) load(r, word(r, k));
    check("full_avail", req_avail_out, 4'h0);
    for (int k = 0; k < 2; k++) for (int r = 0; r < 4; r++) exp_op(r, word(r, k));
    cfg(8, 4'b1111);
    check("busy_run", busy, 1);
    repeat (10) tick();
    check("rr_back_to_back", iss_q.size(), 0);
    wait_idle("rr_all");

    // single requester, third word pushed once space frees
    load(0, 32'h0000_0302); load(0, 32'h0000_0404);
    exp_op(0, 32'h0000_0302); exp_op(0, 32'h0000_0404); exp_op(0, 32'h0000_05FF);
    cfg(3, 4'b0001);
    load(0, 32'h0000_05FF);
    wait_idle("single");

    // mask 0101: only 0 and 2 granted, 1 and 3 keep their words
    do_reset();
    for (int r = 0; r < 4; r++) for (int k = 0; k < 2; k++) load(r, word(r, k + 4));
    exp_op(0, word(0, 4)); exp_op(2, word(2, 4)); exp_op(0, word(0, 5)); exp_op(2, word(2, 5));
    cfg(4, 4'b0101);
    wait_idle("mask");
    check("mask_hold", req_avail_out, 4'b0101);

    // requester 1 back-pressures the head result; MUL fills and grants stop
    do_reset();
    for (int r = 0; r < 4; r++) for (int k = 0; k < 2; k++) load(r, word(r, k + 2));
    for (int k = 0; k < 2; k++) for (int r = 0; r < 4; r++) exp_op(r, word(r, k + 2));
    rsp_avail_in = 4'b1101;
    cfg(8, 4'b1111);
    repeat (10) tick();
    check("hold_mul_avail_out", mul_avail_out, 0);
    check("hold_mul_avail_in", mul_avail_in, 0);
    check("hold_no_issue", mul_valid_out, 0);
    check("hold_issued", iss_q.size(), 3);
    check("hold_delivered", rsp_q.size(), 7);
    rsp_avail_in = 4'b1111;
    wait_idle("hold");

    // num_ops = 0 pulses done next cycle without going busy
    cfg(0, 4'b1111);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    tick();
    check("zero_done_clear", done, 0);
    check("zero_done_cnt", done_cnt, 1);
    done_cnt = 0;

    // configure during RUN is ignored
    load(0, word(0, 6)); load(0, word(0, 7));
    exp_op(0, word(0, 6)); exp_op(0, word(0, 7));
    cfg(2, 4'b0001);
    cfg(5, 4'b1111);
    wait_idle("cfg_ignored");

    // reset with two tags outstanding
    rsp_avail_in = 4'b0000;
    load(0, word(0, 8)); load(0, word(0, 9));
    iss_q.push_back(word(0, 8)); iss_q.push_back(word(0, 9));
    cfg(4, 4'b0001);
    repeat (6) tick();
    check("mid_busy", busy, 1);
    check("mid_issued", iss_q.size(), 0);
    rst = 1'b0; tick();
    check_reset("mid_reset");
    iss_q.delete(); rsp_q.delete(); done_cnt = 0;
    rsp_avail_in = 4'b1111;
    rst = 1'b1; tick();
    load(2, word(2, 9));
    exp_op(2, word(2, 9));
    cfg(1, 4'b0100);
    wait_idle("post_reset");

    // blocked MUL input for six RUN cycles
    mul_block = 1'b1;
    load(1, word(1, 10)); load(1, word(1, 11));
    exp_op(1, word(1, 10)); exp_op(1, word(1, 11));
    exp_stall = 0;
    cfg(2, 4'b0010);
    repeat (6) tick();
    mul_block = 1'b0;
    wait_idle("stats");
`ifdef MUL_ARB_STATS_EN
    check("stall_cycles", stall_cycles, 64'(exp_stall));
`else
    check("stall_cycles", stall_cycles, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one MUL instance among NUM_REQ requesters. Each requester sends packed {rep_info, weight, activation} words.
- Buffers each requester's words, grants the MUL input round-robin, and issues a bounded number of operations per configuration.
- Records the ID of each issued requester in an in-order tag FIFO and routes each MUL result back to the requester that issued it.
- Sits between the activation/weight distribution logic and MUL, and drives MUL's input and output handshakes.

Parameters:
NUM_REQ, 4, number of requesters
LOG_NUM_REQ, 2, bits for requester ID
DATA_WIDTH, 8, activation/weight width
REP_INFO, 16, repetition-info width
LOG_MAX_OPS, 16, width of op counters
TAG_SLOTS, 8, tag FIFO depth (>= MUL FIFO depth + 2)
LOG_TAG_SLOTS, 3, log2(TAG_SLOTS)
Derived: W = 2*DATA_WIDTH + REP_INFO (input and output word width)

Ports:
clk  in  1  clock
rst  in  1  reset
configure  in  1  start pulse
num_ops  in  LOG_MAX_OPS  total operations to issue
enable_mask  in  NUM_REQ  requesters eligible for grant
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the last response is delivered
req_data_in  in  NUM_REQ*W  requester i at [i*W +: W]
req_valid_in  in  NUM_REQ  push strobe per requester
req_avail_out  out  NUM_REQ  requester buffer can accept
mul_data_out  out  W  to MUL data_in
mul_valid_out  out  1  to MUL valid_in
mul_avail_in  in  1  from MUL avail_out
mul_data_in  in  W  from MUL data_out
mul_valid_in  in  1  from MUL valid_out
mul_avail_out  out  1  to MUL avail_in
rsp_data_out  out  W  result broadcast to all requesters
rsp_valid_out  out  NUM_REQ  one-hot result strobe
rsp_avail_in  in  NUM_REQ  requester can accept a result
stall_cycles  out  32  stats counter (see Optional Feature)

Behaviour:
Reset:
- Reset rst, synchronous, active-low; clock clk.
- On reset: state IDLE, all buffers and the tag FIFO empty, round-robin pointer 0, counters 0.
- Output reset values: busy=0, done=0, mul_valid_out=0, mul_data_out=0, rsp_valid_out=0, mul_avail_out=0, req_avail_out all 1, stall_cycles=0.

Requester buffers:
- One 2-slot FIFO per requester.
- req_avail_out[i] = (count_i != 2), driven from the registered count.
- A push is valid only when avail is high in the same cycle. A push while full is dropped; the bench flags it as an error.
- Buffers accept pushes in every state.

State machine: IDLE, RUN, DRAIN.
- IDLE: no grants. configure moves to RUN with issue_cnt = resp_cnt = num_ops and enable_mask latched.
- configure with num_ops = 0 stays in IDLE and pulses done on the next cycle.
- configure outside IDLE is ignored.
- RUN: grant when issue_cnt > 0, mul_avail_in = 1, the tag FIFO is not full, and at least one enabled buffer is non-empty.
- Grant selects the first non-empty enabled requester at or after the pointer, cyclically. The pointer then moves to grant+1 mod NUM_REQ.
- On a grant:
  - pop the granted buffer;
  - register the word into mul_data_out with mul_valid_out = 1 on the next cycle (1-cycle issue latency);
  - push the grant ID into the tag FIFO;
  - decrement issue_cnt.
- When issue_cnt reaches 0, move to DRAIN.
- DRAIN: no grants. When resp_cnt reaches 0: done pulses for 1 cycle, state returns to IDLE.
- The one-cycle slack between sampling mul_avail_in and mul_valid_out is covered by MUL's almost-full avail.

Return path (combinational):
- head = tag FIFO head.
- mul_avail_out = ~tag_empty & rsp_avail_in[head].
- rsp_data_out = mul_data_in.
- rsp_valid_out = mul_valid_in ? onehot(head) : 0.
- When mul_valid_in is high: pop the tag FIFO and decrement resp_cnt.
- A tag push and pop in the same cycle leave the occupancy unchanged.

Boundary cases:
- A requester whose mask bit is 0 is never granted; its buffered words remain.
- All enabled buffers empty: no grant, and the pointer holds.
- Reset mid-operation discards buffered words, tags and in-flight state. MUL shares rst.
- Results are delivered strictly in issue order.

Optional Feature:
MUL_ARB_STATS_EN:
- Defined: stall_cycles increments (saturating) on each RUN cycle with issue_cnt > 0 and a non-empty enabled buffer but no grant. It clears on configure.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Single requester 0, num_ops=3, words 0x0000_0302, 0x0000_0404, 0x0000_05FF -> results 0x0006, 0x0010, 0x04FB on rsp_valid_out=0001; done pulses once; busy falls with done.
- All 4 buffers full, mask 1111, num_ops=8 -> grant order 0,1,2,3,0,1,2,3; one grant per cycle while MUL avail; each result routed to its originator.
- Mask 0101 with all buffers loaded, num_ops=4 -> grants 0,2,0,2 only; requesters 1 and 3 keep req_avail_out=0.
- rsp_avail_in[1]=0 for 10 cycles while the head tag is 1 -> mul_avail_out=0; MUL fills and mul_avail_in drops; grants stop; no result is lost or reordered after release.
- configure num_ops=0 -> done at cycle+1, busy stays 0; configure during RUN -> ignored, original count completes.
- Assert rst mid-RUN with 2 tags outstanding -> next cycle all outputs at reset values, req_avail_out=1111; a new configure runs cleanly. With MUL_ARB_STATS_EN, check stall_cycles against the count of blocked cycles.
